// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM control unit.
// Contents: FSM state enum, Op/ALU/Cond encodings, mux select constants, the
// registered Moore control word and its per-state decode.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  // Instr[27:26]
  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;

  // ALUControl codes
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  // Funct[4:1] data-processing commands
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdOrr = 4'b1100;

  // Condition field codes
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  // ALUSrcB selects
  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // Ungated Moore control word, one per state.
  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SrcBFour;
        c.result_src = ResAluResult;
      end
      StDecode: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SrcBFour;
        c.result_src = ResAluResult;
      end
      StMemAdr:   c.alu_src_b = SrcBImm;
      StMemRead:  c.adr_src = 1'b1;
      StMemWrite: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      StMemWb: begin
        c.result_src = ResData;
        c.reg_w      = 1'b1;
      end
      StExecuteR: begin
        c.alu_src_b = SrcBRd2;
        c.alu_op    = 1'b1;
      end
      StExecuteI: begin
        c.alu_src_b = SrcBImm;
        c.alu_op    = 1'b1;
      end
      StAluWb: begin
        c.result_src = ResAluOut;
        c.reg_w      = 1'b1;
      end
      StBranch: begin
        c.alu_src_b  = SrcBImm;
        c.result_src = ResAluResult;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath bundle for the multicycle ARM core.
// master: the controller (takes instruction fields and ALU flags, drives
// enables and mux selects). slave: the datapath side.
interface arm_mc_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] RegSrc;
  logic [1:0] ImmSrc;
  logic [1:0] ALUControl;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, RegSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, RegSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/arm_mc_condlogic.sv
// Condition unit: NZCV flag register, condition evaluation, the per-instruction
// CondExReg and gating of all datapath write enables.
// Ports: clk/Reset; cond_i, alu_flags_i, flag_w_i, flag_en_i (execute state),
// latch_cond_i (decode state); ungated next_pc_i/pcs_i/reg_w_i/mem_w_i/
// ir_write_i in; gated pc_write_o/reg_write_o/mem_write_o/ir_write_o out.
module arm_mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       flag_en_i,
  input  logic       latch_cond_i,
  input  logic       next_pc_i,
  input  logic       pcs_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       ir_write_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       ir_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       cond_ex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_i)
      CondEq: cond_ex = z;
      CondNe: cond_ex = ~z;
      CondCs: cond_ex = c;
      CondCc: cond_ex = ~c;
      CondMi: cond_ex = n;
      CondPl: cond_ex = ~n;
      CondVs: cond_ex = v;
      CondVc: cond_ex = ~v;
      CondHi: cond_ex = c & ~z;
      CondLs: cond_ex = ~c | z;
      CondGe: cond_ex = (n == v);
      CondLt: cond_ex = (n != v);
      CondGt: cond_ex = ~z & (n == v);
      CondLe: cond_ex = z | (n != v);
      CondAl: cond_ex = 1'b1;
      CondNv: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d  = flags_q;
    condex_d = latch_cond_i ? cond_ex : condex_q;
    // Flag writes follow the condition latched for this instruction.
    if (flag_en_i && condex_q) begin
      if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Reset kills every write in the same cycle, independent of state.
  assign pc_write_o  = ~Reset & (next_pc_i | (pcs_i & condex_q));
  assign reg_write_o = ~Reset & reg_w_i & condex_q;
  assign mem_write_o = ~Reset & mem_w_i & condex_q;
  assign ir_write_o  = ~Reset & ir_write_i;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM with registered control word, ALU
// decoder and PC-source logic; enable gating lives in arm_mc_condlogic.
// Ports: clk, Reset (sync, active-high), bus (arm_mc_controller_if.master):
// instruction fields and ALU flags in, write enables and mux selects out.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input logic                  clk,
  input logic                  Reset,
  arm_mc_controller_if.master  bus
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [1:0] alu_control;
  logic       cmd_known;
  logic [1:0] flag_w;
  logic       pcs;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (bus.Op)
          OpMem:    state_d = StMemAdr;
          OpDp:     state_d = bus.Funct[5] ? StExecuteI : StExecuteR;
          OpBranch: state_d = StBranch;
          default:  state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = bus.Funct[0] ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Control word is decoded from the next state so it is registered alongside it.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StFetch;
      ctrl_q  <= state_ctrl(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  always_comb begin
    alu_control = AluAdd;
    cmd_known   = 1'b0;
    if (ctrl_q.alu_op) begin
      case (bus.Funct[4:1])
        CmdAdd: begin alu_control = AluAdd; cmd_known = 1'b1; end
        CmdSub: begin alu_control = AluSub; cmd_known = 1'b1; end
        CmdAnd: begin alu_control = AluAnd; cmd_known = 1'b1; end
        CmdOrr: begin alu_control = AluOrr; cmd_known = 1'b1; end
        default: begin alu_control = AluAdd; cmd_known = 1'b0; end
      endcase
    end
    flag_w[1] = cmd_known & bus.Funct[0];
    flag_w[0] = cmd_known & bus.Funct[0] &
                ((alu_control == AluAdd) | (alu_control == AluSub));
  end

  assign pcs = (ctrl_q.reg_w & (bus.Rd == 4'hF)) | ctrl_q.branch;

  arm_mc_condlogic u_condlogic (
    .clk          (clk),
    .Reset        (Reset),
    .cond_i       (bus.Cond),
    .alu_flags_i  (bus.ALUFlags),
    .flag_w_i     (flag_w),
    .flag_en_i    ((state_q == StExecuteR) | (state_q == StExecuteI)),
    .latch_cond_i (state_q == StDecode),
    .next_pc_i    (ctrl_q.next_pc),
    .pcs_i        (pcs),
    .reg_w_i      (ctrl_q.reg_w),
    .mem_w_i      (ctrl_q.mem_w),
    .ir_write_i   (ctrl_q.ir_write),
    .pc_write_o   (bus.PCWrite),
    .reg_write_o  (bus.RegWrite),
    .mem_write_o  (bus.MemWrite),
    .ir_write_o   (bus.IRWrite)
  );

  assign bus.AdrSrc     = ctrl_q.adr_src;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ResultSrc  = ctrl_q.result_src;
  assign bus.ALUControl = alu_control;
  assign bus.RegSrc     = {bus.Op == OpMem, bus.Op == OpBranch};
  assign bus.ImmSrc     = bus.Op;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: directed instruction sequence then randomized
// instructions, each cycle compared against an instruction-level model.
module tb_arm_mc_controller;

  logic clk = 1'b0;
  logic Reset;

  arm_mc_controller_if bus ();

  arm_mc_controller dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int PhFetch    = 0;
  localparam int PhDecode   = 1;
  localparam int PhMemAdr   = 2;
  localparam int PhMemRead  = 3;
  localparam int PhMemWb    = 4;
  localparam int PhMemWrite = 5;
  localparam int PhExecR    = 6;
  localparam int PhExecI    = 7;
  localparam int PhAluWb    = 8;
  localparam int PhBranch   = 9;

  int vectors = 0;
  int miscompares = 0;

  // Architectural model state: NZCV and the condition of the current instruction.
  logic [3:0] mflags = 4'b0000;
  logic       mce = 1'b0;

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,RegSrc,ImmSrc}
  function automatic logic [15:0] observe();
    return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.RegSrc, bus.ImmSrc};
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = observe();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_en_zero(input string tag);
    logic [3:0] obs;
    obs = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite};
    vectors++;
    assert (obs === 4'b0000) else begin
      miscompares++;
      $error("FAIL %s: enables observed %b required 0000", tag, obs);
    end
  endtask

  // Runs one instruction from its FETCH cycle (entered at posedge+1). If
  // abort_at >= 0, Reset is raised in that cycle of the instruction instead.
  task automatic run_instr(input string name, input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] aflags, input int abort_at);
    int ph[$];
    logic [1:0] aluc;
    logic known, rd15;
    logic pcw, mw, rw, irw, adr, srca;
    logic [1:0] srcb, res, ctl, regsrc;
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.ALUFlags = aflags;
    ph.push_back(PhFetch);
    ph.push_back(PhDecode);
    case (op)
      2'b01: begin
        ph.push_back(PhMemAdr);
        if (funct[0]) begin ph.push_back(PhMemRead); ph.push_back(PhMemWb); end
        else ph.push_back(PhMemWrite);
      end
      2'b00: begin
        ph.push_back(funct[5] ? PhExecI : PhExecR);
        ph.push_back(PhAluWb);
      end
      2'b10: ph.push_back(PhBranch);
      default: ;
    endcase
    known = 1'b1;
    case (funct[4:1])
      4'b0100: aluc = 2'b00;
      4'b0010: aluc = 2'b01;
      4'b0000: aluc = 2'b10;
      4'b1100: aluc = 2'b11;
      default: begin aluc = 2'b00; known = 1'b0; end
    endcase
    rd15 = (rd == 4'd15);
    regsrc = {op == 2'b01, op == 2'b10};
    for (int k = 0; k < ph.size(); k++) begin
      if (k == abort_at) begin
        Reset = 1'b1;
        #1;
        check_en_zero($sformatf("%s_reset_c%0d", name, k + 1));
        @(posedge clk);
        #1;
        Reset = 1'b0;
        mflags = 4'b0000;
        mce = 1'b0;
        return;
      end
      {pcw, mw, rw, irw, adr, srca} = 6'b0;
      srcb = 2'b00; res = 2'b00; ctl = 2'b00;
      case (ph[k])
        PhFetch:    begin pcw = 1; irw = 1; srca = 1; srcb = 2'b10; res = 2'b10; end
        PhDecode:   begin srca = 1; srcb = 2'b10; res = 2'b10; end
        PhMemAdr:   srcb = 2'b01;
        PhMemRead:  adr = 1;
        PhMemWrite: begin adr = 1; mw = mce; end
        PhMemWb:    begin res = 2'b01; rw = mce; pcw = mce && rd15; end
        PhExecR:    ctl = aluc;
        PhExecI:    begin ctl = aluc; srcb = 2'b01; end
        PhAluWb:    begin rw = mce; pcw = mce && rd15; end
        PhBranch:   begin srcb = 2'b01; res = 2'b10; pcw = mce; end
        default: ;
      endcase
      #1;
      check($sformatf("%s_c%0d", name, k + 1),
            {pcw, mw, rw, irw, adr, srca, srcb, res, ctl, regsrc, op});
      if (ph[k] == PhDecode) mce = cond_ok(cond, mflags);
      if ((ph[k] == PhExecR || ph[k] == PhExecI) && funct[0] && known && mce) begin
        mflags[3:2] = aflags[3:2];
        if (aluc == 2'b00 || aluc == 2'b01) mflags[1:0] = aflags[1:0];
      end
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};

  initial begin
    logic [3:0] r_cond, r_rd, r_fl;
    logic [1:0] r_op;
    logic [5:0] r_funct;
    int cpi, ab;

    Reset = 1'b1;
    bus.Cond = 4'd0; bus.Op = 2'd0; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_en_zero("in_reset");
    Reset = 1'b0;

    run_instr("ldr",     4'b1110, 2'b01, 6'b011001, 4'd3,  4'b0000, -1);
    run_instr("str",     4'b1110, 2'b01, 6'b011000, 4'd4,  4'b0000, -1);
    run_instr("adds",    4'b1110, 2'b00, 6'b001001, 4'd2,  4'b0100, -1);
    run_instr("beq",     4'b0000, 2'b10, 6'b000000, 4'd0,  4'b0000, -1);
    run_instr("bne",     4'b0001, 2'b10, 6'b000000, 4'd0,  4'b0000, -1);
    run_instr("subne",   4'b0001, 2'b00, 6'b000101, 4'd5,  4'b1011, -1);
    // Z must still be set: a second BEQ still branches.
    run_instr("beq2",    4'b0000, 2'b10, 6'b000000, 4'd0,  4'b0000, -1);
    run_instr("orr_pc",  4'b1110, 2'b00, 6'b111000, 4'd15, 4'b0000, -1);
    run_instr("ldr_rst", 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, 3);
    // Flags cleared by reset: BEQ must not branch.
    run_instr("beq_rst", 4'b0000, 2'b10, 6'b000000, 4'd0,  4'b0000, -1);
    run_instr("nop11",   4'b1110, 2'b11, 6'b000000, 4'd0,  4'b0000, -1);
    run_instr("nv_add",  4'b1111, 2'b00, 6'b101001, 4'd15, 4'b1111, -1);

    for (int i = 0; i < 400; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_cond = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      r_funct = 6'($urandom_range(0, 63));
      if (r_op == 2'b00 && $urandom_range(0, 4) != 0) r_funct[4:1] = cmds[$urandom_range(0, 3)];
      r_rd = ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      r_fl = 4'($urandom_range(0, 15));
      case (r_op)
        2'b01:   cpi = r_funct[0] ? 5 : 4;
        2'b00:   cpi = 4;
        2'b10:   cpi = 3;
        default: cpi = 2;
      endcase
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, cpi - 1) : -1;
      run_instr($sformatf("rnd%0d", i), r_cond, r_op, r_funct, r_rd, r_fl, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Control unit for the multicycle ARM core: sequences a single shared instruction/data memory, the register file, and the ALU across several cycles per instruction. It replaces the single-cycle decoder, driving every mux select and write enable of the multicycle datapath from a Moore state machine plus a condition-flag unit. Supported instructions are LDR/STR (immediate offset), data-processing (ADD, SUB, AND, ORR; register or immediate; optional S), and B.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  datapath write enables
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- RegSrc, ImmSrc  out  2 each  combinational from Op: RegSrc={Op==00?0:1 for STR, Op==10}; ImmSrc=Op
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions: FETCH→DECODE; DECODE→MEMADR (Op=01), EXECUTER (Op=00, Funct[5]=0), EXECUTEI (Op=00, Funct[5]=1), BRANCH (Op=10), FETCH (Op=11, no effect); MEMADR→MEMREAD (Funct[0]=1) else MEMWRITE; MEMREAD→MEMWB→FETCH; MEMWRITE→FETCH; EXECUTER/EXECUTEI→ALUWB→FETCH; BRANCH→FETCH.
- Per-state outputs (unlisted = 0): FETCH AdrSrc=0, IRWrite, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC. DECODE ALUSrcA=1, ALUSrcB=10, ResultSrc=10. MEMADR ALUSrcB=01, ALUOp=0. MEMREAD/MEMWRITE AdrSrc=1; MEMWRITE adds MemW. MEMWB ResultSrc=01, RegW. EXECUTER ALUSrcB=00, ALUOp=1; EXECUTEI ALUSrcB=01, ALUOp=1. ALUWB ResultSrc=00, RegW. BRANCH ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch.
- ALU decode: ALUOp=0 → ADD, FlagW=00. ALUOp=1 → Funct[4:1] 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other cmd → ADD with FlagW=00. FlagW[1]=Funct[0] (writes N,Z); FlagW[0]=Funct[0]&(ADD|SUB) (writes C,V).
- PCS = (RegW & Rd==15) | Branch.
- Condition: CondEx from Cond vs flag register: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 → 0. CondEx latched into CondExReg at end of DECODE; all later states use CondExReg.
- Gating: PCWrite = NextPC | (PCS & CondExReg); RegWrite = RegW & CondExReg; MemWrite = MemW & CondExReg; flags NZ load ALUFlags[3:2] when FlagW[1]&CondExReg, CV load [1:0] when FlagW[0]&CondExReg, only in EXECUTER/EXECUTEI.

## Timing
- CPI: LDR 5, STR 4, data-processing 4, B 3, Op=11 2.
- Flag register updates at the edge ending EXECUTE*; visible to the next instruction's DECODE.
- Reset: while Reset=1, PCWrite, MemWrite, RegWrite, IRWrite forced 0 combinationally; next state FETCH, flags 0000, CondExReg 0. First cycle after release: FETCH outputs (PCWrite=1, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0, ALUControl=00).
- Reset mid-instruction (any state): pending write suppressed in that cycle; no partial write afterwards.
- Failed condition: instruction still traverses all its states; only enables are suppressed.

## Structure
- Package arm_mc_pkg: state enum (4-bit), Op encodings, ALUControl codes, Cond codes, ALUSrcB/ResultSrc select constants.
- Sub-module arm_mc_condlogic: flag register, CondEx evaluation, CondExReg, enable gating. Top holds state register, next-state logic, output decode, ALU decoder.

## Test plan
- Reset, then LDR (Op=01, Funct=011001, Cond=1110): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; RegWrite=1 only in cycle 5; AdrSrc=1 in cycle 4.
- STR (Funct=011000): MemWrite=1 only in cycle 4; RegWrite never 1.
- ADDS reg (Op=00, Funct=001001, ALUFlags=0100): ALUControl=00 in EXECUTER; flags=0100 after; next BEQ (Op=10, Cond=0000): PCWrite=1 in BRANCH.
- BNE (Cond=0001) with Z=1: PCWrite=1 only in FETCH, 0 in BRANCH; SUB with Cond=0001: RegWrite=0 in ALUWB, flags unchanged.
- ORR imm to Rd=15 (Funct=111000): ALUControl=11, ALUSrcB=01 in EXECUTEI; PCWrite=1 and RegWrite=1 in ALUWB.
- Reset asserted during MEMREAD of LDR: all enables 0 that cycle, no RegWrite, following cycle FETCH with flags 0000.
